mc_controller: RTL and testbench

Multi-cycle control sequencer for the miniRV core. It replaces the single-cycle decode-only controller when instruction ROM and data RAM are variable-latency and each need a request/acknowledge handshake. The block walks each instruction through FETCH, DECODE, EXEC, MEM and WB. It raises the per-cycle write strobes for the PC, IR, register file and DRAM, and counts retired instructions. It sits between the instruction register and the existing datapath; the combinational sext/alu/wsel decode stays outside it.

---
 rtl/mc_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control sequencer for the miniRV core.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB with
// request/acknowledge handshakes to a variable-latency instruction ROM and
// data RAM. It raises the per-cycle strobes for PC, IR, register file and
// DRAM, and counts retired instructions (one per PC update).
//
// Optional build macro: MEM_TIMEOUT_EN
//   When defined, a wait counter traps the block after TIMEOUT+1 consecutive
//   unacknowledged FETCH or MEM cycles. When undefined, the block waits
//   indefinitely and TRAP is reachable only through an illegal opcode.
//
// Parameters
//   TIMEOUT  max wait cycles on a handshake before trapping (MEM_TIMEOUT_EN)
//   TO_W     wait counter width; TIMEOUT must be < 2**TO_W
// Ports
//   cpu_clk, cpu_rst       clock, synchronous active-high reset
//   inst[31:0]             current IR contents
//   zero, sgn              ALU flags, valid in EXEC
//   irom_ack, dram_ack     handshake acknowledges
//   irom_req, ir_we        fetch request, IR capture strobe
//   dram_req, dram_we      data request, store qualifier
//   rf_we, pc_we           register-file / PC write strobes
//   npc_op[1:0]            next-PC select (PC_4 / PC_IMM / RD1_IMM)
//   trap                   sticky fault indicator
//   state[2:0]             FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   instret[31:0]          retired-instruction counter
module mc_controller #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        sgn,
  input  logic        irom_ack,
  input  logic        dram_ack,
  output logic        irom_req,
  output logic        ir_we,
  output logic        dram_req,
  output logic        dram_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  npc_op,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  // next-PC select encodings shared with the datapath
  localparam logic [1:0] PC_4    = 2'd0;
  localparam logic [1:0] PC_IMM  = 2'd1;
  localparam logic [1:0] RD1_IMM = 2'd2;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_B    = 7'h63;
  localparam logic [6:0] OP_U    = 7'h37;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       legal, br_taken;
  logic       to_hit;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Only opcode and funct3 steer the sequencer; the rest of the IR is decoded
  // by the datapath.
  logic unused_inst;
  assign unused_inst = ^{inst[31:15], inst[11:7]};

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_U, OP_JAL, OP_JALR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Only BEQ/BNE/BLT/BGE can be taken; other funct3 values fall through.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = sgn;
      3'b101:  br_taken = ~sgn;
      default: br_taken = 1'b0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [TO_W-1:0] to_max = TO_W'(TIMEOUT);

  logic [TO_W-1:0] wait_q, wait_d;

  // Counts consecutive unacknowledged request cycles. Any other cycle
  // (including an ack) clears it, so it starts at 0 on each FETCH/MEM entry.
  always_comb begin
    wait_d = '0;
    if (!cpu_rst &&
        ((state_q == S_FETCH && !irom_ack) || (state_q == S_MEM && !dram_ack)))
      wait_d = wait_q + TO_W'(1);
  end

  assign to_hit = (wait_q == to_max);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) wait_q <= '0;
    else         wait_q <= wait_d;
  end
`else
  localparam int unused_to_cfg = TIMEOUT + TO_W;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    irom_req = 1'b0;
    ir_we    = 1'b0;
    dram_req = 1'b0;
    dram_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    npc_op   = PC_4;
    trap     = 1'b0;

    case (state_q)
      S_FETCH: begin
        irom_req = 1'b1;
        if (irom_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (opcode == OP_B) begin
          pc_we   = 1'b1;
          npc_op  = br_taken ? PC_IMM : PC_4;
          state_d = S_FETCH;
        end else if (opcode == OP_LOAD || opcode == OP_S) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dram_req = 1'b1;
        dram_we  = (opcode == OP_S);
        if (dram_ack) begin
          if (opcode == OP_S) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        if (opcode == OP_JAL)       npc_op = PC_IMM;
        else if (opcode == OP_JALR) npc_op = RD1_IMM;
      end
      S_TRAP: trap = 1'b1;
      default: begin
        // unused encodings are treated as a fault
        trap    = 1'b1;
        state_d = S_TRAP;
      end
    endcase

    // Reset masks every output combinationally so nothing leaks in the
    // cycle reset is first seen, before the state register has cleared.
    if (cpu_rst) begin
      state_d  = S_FETCH;
      irom_req = 1'b0;
      ir_we    = 1'b0;
      dram_req = 1'b0;
      dram_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      npc_op   = PC_4;
      trap     = 1'b0;
    end

    instret_d = instret_q + 32'(pc_we);
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = cpu_rst ? 3'd0  : state_q;
  assign instret = cpu_rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed scoreboard bench for mc_controller: each cycle's expected output
// vector is queued as the stimulus is driven and popped when sampled on the
// falling edge.
module tb_mc_controller;

  localparam logic [1:0] PC4    = 2'd0;
  localparam logic [1:0] PCIMM  = 2'd1;
  localparam logic [1:0] RD1IMM = 2'd2;

  localparam logic [31:0] ADD  = 32'h003100B3;
  localparam logic [31:0] BNE  = 32'h00209463;
  localparam logic [31:0] BLT  = 32'h0020C463;
  localparam logic [31:0] BGE  = 32'h0020D463;
  localparam logic [31:0] B010 = 32'h0020A463;
  localparam logic [31:0] LW   = 32'h0000A083;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] JAL  = 32'h008000EF;
  localparam logic [31:0] JALR = 32'h000080E7;
  localparam logic [31:0] LUI  = 32'h000010B7;
  localparam logic [31:0] ADDI = 32'h00108093;
  localparam logic [31:0] ILL  = 32'h0000007F;

  // flag order: irom_req, ir_we, dram_req, dram_we, rf_we, pc_we
  typedef struct packed {
    logic [2:0]  st;
    logic [5:0]  fl;
    logic [1:0]  npc;
    logic        tr;
    logic [31:0] ir;
  } vec_t;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] inst;
  logic        zero, sgn, irom_ack, dram_ack;
  logic        irom_req, ir_we, dram_req, dram_we, rf_we, pc_we, trap;
  logic [1:0]  npc_op;
  logic [2:0]  state;
  logic [31:0] instret;

  vec_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   ret    = 0;

  mc_controller #(.TIMEOUT(4), .TO_W(8)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .inst(inst), .zero(zero), .sgn(sgn),
    .irom_ack(irom_ack), .dram_ack(dram_ack), .irom_req(irom_req), .ir_we(ir_we),
    .dram_req(dram_req), .dram_we(dram_we), .rf_we(rf_we), .pc_we(pc_we),
    .npc_op(npc_op), .trap(trap), .state(state), .instret(instret)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic vec_t ex(logic [2:0] st, logic [5:0] fl, logic [1:0] npc,
                              logic tr, int r);
    vec_t v;
    v.st = st; v.fl = fl; v.npc = npc; v.tr = tr; v.ir = 32'(r);
    return v;
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic [31:0] i,
                     input logic ia, input logic da, input logic z, input logic s,
                     input vec_t e);
    vec_t obs, exp_v;
    cpu_rst = rst; inst = i; irom_ack = ia; dram_ack = da; zero = z; sgn = s;
    sb.push_back(e);
    @(negedge cpu_clk);
    obs.st  = state;
    obs.fl  = {irom_req, ir_we, dram_req, dram_we, rf_we, pc_we};
    obs.npc = npc_op;
    obs.tr  = trap;
    obs.ir  = instret;
    exp_v = sb.pop_front();
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    if (rst) ret = 0;
    else if (exp_v.fl[0]) ret++;
    @(posedge cpu_clk); #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] i, input int dly);
    for (int k = 0; k < dly; k++)
      cyc(tag, 1'b0, i, 1'b0, 1'b1, 1'b0, 1'b0, ex(3'd0, 6'b100000, PC4, 1'b0, ret));
    cyc(tag, 1'b0, i, 1'b1, 1'b0, 1'b0, 1'b0, ex(3'd0, 6'b110000, PC4, 1'b0, ret));
  endtask

  // acks held high in DECODE must be ignored
  task automatic decode(input string tag, input logic [31:0] i);
    cyc(tag, 1'b0, i, 1'b1, 1'b1, 1'b0, 1'b0, ex(3'd1, 6'b000000, PC4, 1'b0, ret));
  endtask

  task automatic exec_plain(input string tag, input logic [31:0] i);
    cyc(tag, 1'b0, i, 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd2, 6'b000000, PC4, 1'b0, ret));
  endtask

  task automatic wb(input string tag, input logic [31:0] i, input logic [1:0] npc);
    cyc(tag, 1'b0, i, 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd4, 6'b000011, npc, 1'b0, ret));
  endtask

  task automatic branch(input string tag, input logic [31:0] i, input logic z,
                        input logic s, input logic [1:0] npc);
    fetch(tag, i, 0);
    decode(tag, i);
    cyc(tag, 1'b0, i, 1'b0, 1'b0, z, s, ex(3'd2, 6'b000001, npc, 1'b0, ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rst = 1'b1; inst = ADD; irom_ack = 1'b0; dram_ack = 1'b0;
    zero = 1'b0; sgn = 1'b0;
    @(posedge cpu_clk); #1;

    // reset: every output 0 even with acks high
    cyc("reset0", 1'b1, ADD, 1'b1, 1'b1, 1'b1, 1'b1, '0);
    cyc("reset1", 1'b1, ADD, 1'b1, 1'b1, 1'b1, 1'b1, '0);

    // R-type add: 0,1,2,4 then FETCH with instret 1
    fetch("add_f", ADD, 0);
    decode("add_d", ADD);
    exec_plain("add_e", ADD);
    wb("add_wb", ADD, PC4);

    branch("bne_taken", BNE, 1'b0, 1'b0, PCIMM);
    branch("bne_not",   BNE, 1'b1, 1'b0, PC4);
    branch("blt_taken", BLT, 1'b0, 1'b1, PCIMM);
    branch("bge_not",   BGE, 1'b0, 1'b1, PC4);
    branch("b010_not",  B010, 1'b1, 1'b0, PC4);

    // load, dram_ack delayed 3 cycles; stray irom_ack in MEM ignored
    fetch("lw_f", LW, 0);
    decode("lw_d", LW);
    exec_plain("lw_e", LW);
    for (int k = 0; k < 3; k++)
      cyc("lw_mwait", 1'b0, LW, 1'b1, 1'b0, 1'b0, 1'b0, ex(3'd3, 6'b001000, PC4, 1'b0, ret));
    cyc("lw_mack", 1'b0, LW, 1'b0, 1'b1, 1'b0, 1'b0, ex(3'd3, 6'b001000, PC4, 1'b0, ret));
    wb("lw_wb", LW, PC4);

    // store, immediate ack: req, we and pc_we together
    fetch("sw_f", SW, 0);
    decode("sw_d", SW);
    exec_plain("sw_e", SW);
    cyc("sw_m", 1'b0, SW, 1'b0, 1'b1, 1'b0, 1'b0, ex(3'd3, 6'b001101, PC4, 1'b0, ret));

    // JAL with fetch delayed 2 cycles
    fetch("jal_f", JAL, 2);
    decode("jal_d", JAL);
    exec_plain("jal_e", JAL);
    wb("jal_wb", JAL, PCIMM);

    fetch("jalr_f", JALR, 0);
    decode("jalr_d", JALR);
    exec_plain("jalr_e", JALR);
    wb("jalr_wb", JALR, RD1IMM);

    fetch("lui_f", LUI, 0);
    decode("lui_d", LUI);
    exec_plain("lui_e", LUI);
    wb("lui_wb", LUI, PC4);

    fetch("addi_f", ADDI, 0);
    decode("addi_d", ADDI);
    exec_plain("addi_e", ADDI);
    wb("addi_wb", ADDI, PC4);

`ifndef MEM_TIMEOUT_EN
    // without the timeout feature a long ack delay just stretches FETCH
    fetch("long_f", ADD, 8);
    decode("long_d", ADD);
    exec_plain("long_e", ADD);
    wb("long_wb", ADD, PC4);
`endif

    // illegal opcode: DECODE -> TRAP, held with no strobes
    fetch("ill_f", ILL, 0);
    cyc("ill_d", 1'b0, ILL, 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd1, 6'b000000, PC4, 1'b0, ret));
    for (int k = 0; k < 20; k++)
      cyc("ill_trap", 1'b0, ILL, k[0], k[1], k[2], 1'b0, ex(3'd5, 6'b000000, PC4, 1'b1, ret));

    // reset clears trap, state and instret
    cyc("trap_rst", 1'b1, ADD, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    fetch("post_rst_f", ADD, 0);
    decode("post_rst_d", ADD);
    exec_plain("post_rst_e", ADD);
    // reset lands where WB would have been: nothing retires
    cyc("abort_rst", 1'b1, ADD, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    fetch("abort_f", ADD, 1);
    decode("abort_d", ADD);

`ifdef MEM_TIMEOUT_EN
    // TIMEOUT=4: five unacknowledged FETCH cycles, then TRAP
    cyc("to_rst", 1'b1, ADD, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++)
      cyc("to_wait", 1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd0, 6'b100000, PC4, 1'b0, ret));
    cyc("to_trap", 1'b0, ADD, 1'b1, 1'b0, 1'b0, 1'b0, ex(3'd5, 6'b000000, PC4, 1'b1, ret));
    // ack in the fifth cycle wins
    cyc("to_rst2", 1'b1, ADD, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    fetch("to_ack5", ADD, 4);
    decode("to_ack5_d", ADD);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
